mbc5_bus_master: RTL
====================

# mbc5_bus_master

Game Boy cartridge bus initiator for MBC5 cartridges. It accepts linear ROM/RAM access requests over a valid/ready interface and expands each one into Game Boy bus cycles: MBC5 bank-select writes, RAM-enable writes, then the data access. It sits between a host-side loader/dumper and the cartridge bus, so it is the counterpart of the MBC5 mapper on that bus.

## Interface
- STROBE_CYCLES, 2, cycles bus_wr/bus_rd are held high per bus cycle (≥1)
- vb_clk  in  1  system clock
- vb_rst  in  1  reset: asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request; high only in IDLE
- req_ram  in  1  1 = cartridge RAM space, 0 = ROM space
- req_we  in  1  1 = write, 0 = read
- req_addr  in  23  linear address: ROM uses [22:0]; RAM uses [16:0], with [22:17] ignored
- req_wdata  in  8  write data
- resp_valid  out  1  one-cycle completion pulse, for reads and writes
- resp_rdata  out  8  read data; held until the next read completes
- bus_a  out  16  cartridge address
- bus_dout  out  8  data driven to the cartridge
- bus_doe  out  1  bus_dout output enable
- bus_din  in  8  data from the cartridge
- bus_wr  out  1  write strobe, active-high
- bus_rd  out  1  read strobe, active-high

## Operation
- Address mapping:
  - ROM with addr[22:14]==0: bus_a = {2'b00, addr[13:0]}; no bank write.
  - ROM otherwise: bank = addr[22:14], bus_a = {2'b01, addr[13:0]}.
  - RAM: bank = addr[16:13], bus_a = 16'hA000 | addr[12:0].
- ROM write (req_ram=0, req_we=1) is a raw MBC register write: bus_a = {1'b0, addr[14:0]} with no bank writes. It invalidates the ROM-bank and RAM-bank caches and clears ram_on.
- FSM states: IDLE, BANK_LO, BANK_HI, RAM_EN, RAM_BANK, ACCESS, RESP.
- IDLE goes to the first required state in this fixed order:
  - BANK_LO: write addr[21:14] to 16'h2000.
  - BANK_HI: write {7'b0, addr[22]} to 16'h3000.
  - RAM_EN: write 8'h0A to 16'h0000; taken only when ram_on=0, then sets ram_on.
  - RAM_BANK: write {4'b0, addr[16:13]} to 16'h4000.
  - ACCESS, then RESP, then IDLE.
- ROM banked requests use BANK_LO and BANK_HI. RAM requests use RAM_EN and RAM_BANK.
- Each bus cycle has three phases:
  - SETUP: 1 cycle. bus_a valid; bus_dout/bus_doe valid for writes; strobes low.
  - STROBE: STROBE_CYCLES cycles with the strobe high.
  - HOLD: 1 cycle. Strobes low; bus_a, bus_dout and bus_doe unchanged.
- Read data is sampled from bus_din on the last STROBE cycle and copied to resp_rdata in RESP.
- Between bus cycles, bus_wr and bus_rd are never both high. bus_doe is low during every read cycle and whenever the FSM is in IDLE.
- Request fields are registered at acceptance; later changes on req_* have no effect.

## Timing
- Reset values:
  - req_ready=1 once out of reset, 0 while vb_rst=1.
  - resp_valid=0, resp_rdata=8'h00, bus_a=16'h0000, bus_dout=8'h00.
  - bus_doe=0, bus_wr=0, bus_rd=0.
  - ROM/RAM bank caches invalid, ram_on=0.
- Reset asserted mid-transaction forces all of the above immediately (asynchronous). The request in flight is dropped with no resp_valid.
- Bus cycle length: B = STROBE_CYCLES+2 clocks.
- Latency:
  - Acceptance edge is T0. Bus cycle k (k=0..N-1) occupies T(1+kB) through T(B+kB).
  - resp_valid is high in cycle T(1+NB) only, and req_ready returns high at T(2+NB).
  - Back-to-back requests: minimum gap of NB+2 cycles between acceptances.
- A bank write updates its cache entry at the end of its HOLD phase.

## Configuration
- MBC5_MASTER_BANK_CACHE_EN defined: cached ROM bank (9b + valid) and RAM bank (4b + valid) are kept. BANK_LO, BANK_HI and RAM_BANK are skipped when the cached value matches and is valid; ROM requests with bank 0 never touch the cache.
- Not defined: no cache. Every banked ROM request issues BANK_LO and BANK_HI, and every RAM request issues RAM_BANK. RAM_EN still occurs only once, gated by ram_on.

## Test plan
- After reset, ROM read of 23'h000123 with bus_din=8'h5A: one read cycle at bus_a=16'h0123. resp_valid at T5 (STROBE_CYCLES=2); resp_rdata=8'h5A.
- ROM read of 23'h1A4567: writes 8'h69→16'h2000 and 8'h00→16'h3000, then a read at 16'h4567; resp_valid at T13. An immediate repeat read, with the cache macro defined, performs a single read cycle (resp at T5).
- ROM read of 23'h400000: BANK_HI writes 8'h01 to 16'h3000 and BANK_LO writes 8'h00 to 16'h2000; read at 16'h4000.
- RAM write of 8'hC3 to 17'h1E005:
  - Bus sequence: 8'h0A→16'h0000, 8'h0F→16'h4000, 8'hC3→16'hA005.
  - bus_doe high only during those write cycles.
  - A second RAM write to the same bank issues only the data cycle (macro defined).
- Raw ROM write 8'h00 to 23'h000000, then a RAM read: RAM_EN is reissued, because ram_on and the caches were cleared.
- Assert vb_rst during the STROBE phase of BANK_LO: bus_wr drops in the same cycle, no resp_valid is produced, and the next request re-issues all bank writes.

Source files
------------

// File: rtl/mbc5_bus_master_if.sv
// Request/response and cartridge-bus signal bundle for mbc5_bus_master.
// The master modport is the block's view; the slave modport is the host/cartridge view.
interface mbc5_bus_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_ram;
  logic        req_we;
  logic [22:0] req_addr;
  logic [7:0]  req_wdata;
  logic        resp_valid;
  logic [7:0]  resp_rdata;
  logic [15:0] bus_a;
  logic [7:0]  bus_dout;
  logic        bus_doe;
  logic [7:0]  bus_din;
  logic        bus_wr;
  logic        bus_rd;

  modport master (
    input  req_valid, req_ram, req_we, req_addr, req_wdata, bus_din,
    output req_ready, resp_valid, resp_rdata, bus_a, bus_dout, bus_doe, bus_wr, bus_rd
  );

  modport slave (
    output req_valid, req_ram, req_we, req_addr, req_wdata, bus_din,
    input  req_ready, resp_valid, resp_rdata, bus_a, bus_dout, bus_doe, bus_wr, bus_rd
  );
endinterface

// File: rtl/mbc5_bus_master.sv
// MBC5 cartridge bus initiator: expands linear ROM/RAM requests into bank-select,
// RAM-enable and data bus cycles. Define MBC5_MASTER_BANK_CACHE_EN to skip redundant bank writes.
module mbc5_bus_master #(
  parameter int STROBE_CYCLES = 2
) (
  input logic               vb_clk,
  input logic               vb_rst,
  mbc5_bus_master_if.master bus
);
  localparam int PW = $clog2(STROBE_CYCLES + 2);
  localparam logic [PW-1:0] PH_LAST = PW'(STROBE_CYCLES + 1);
  localparam logic [PW-1:0] PH_SMP  = PW'(STROBE_CYCLES);

  typedef enum logic [2:0] {
    IDLE, BANK_LO, BANK_HI, RAM_EN, RAM_BANK, ACCESS, RESP
  } state_e;

  state_e      state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [3:0]  need_q, need_d;   // {bank_lo, bank_hi, ram_en, ram_bank}
  logic        ram_q, ram_d, we_q, we_d;
  logic [22:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        ram_on_q, ram_on_d;
  logic [7:0]  rd_smp_q, rd_smp_d;
  logic [7:0]  rdata_q, rdata_d;
`ifdef MBC5_MASTER_BANK_CACHE_EN
  logic [8:0]  rom_bank_q, rom_bank_d;
  logic        rom_val_q, rom_val_d;
  logic [3:0]  ram_bank_q, ram_bank_d;
  logic        ram_val_q, ram_val_d;
`endif

  logic [8:0]  in_bank;
  logic        rom_banked, need_rom, need_en, need_rb;
  logic [3:0]  need_in;

  // First required step strictly after `st`, in the fixed bus-cycle order.
  function automatic state_e next_step(state_e st, logic [3:0] need);
    state_e r;
    r = ACCESS;
    if (st == IDLE && need[3])                                     r = BANK_LO;
    else if ((st == IDLE || st == BANK_LO) && need[2])             r = BANK_HI;
    else if ((st == IDLE || st == BANK_LO || st == BANK_HI) && need[1]) r = RAM_EN;
    else if (st != ACCESS && st != RAM_BANK && st != RESP && need[0])   r = RAM_BANK;
    return r;
  endfunction

  always_comb begin
    in_bank    = bus.req_addr[22:14];
    rom_banked = !bus.req_ram && !bus.req_we && (in_bank != 9'd0);
    need_en    = bus.req_ram && !ram_on_q;
`ifdef MBC5_MASTER_BANK_CACHE_EN
    need_rom   = rom_banked && !(rom_val_q && rom_bank_q == in_bank);
    need_rb    = bus.req_ram && !(ram_val_q && ram_bank_q == bus.req_addr[16:13]);
`else
    need_rom   = rom_banked;
    need_rb    = bus.req_ram;
`endif
    need_in    = {need_rom, need_rom, need_en, need_rb};
  end

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    need_d   = need_q;
    ram_d    = ram_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ram_on_d = ram_on_q;
    rd_smp_d = rd_smp_q;
    rdata_d  = rdata_q;
`ifdef MBC5_MASTER_BANK_CACHE_EN
    rom_bank_d = rom_bank_q;
    rom_val_d  = rom_val_q;
    ram_bank_d = ram_bank_q;
    ram_val_d  = ram_val_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          ram_d   = bus.req_ram;
          we_d    = bus.req_we;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          need_d  = need_in;
          state_d = next_step(IDLE, need_in);
          phase_d = '0;
        end
      end
      RESP: state_d = IDLE;
      default: begin
        if (state_q == ACCESS && !we_q && phase_q == PH_SMP) rd_smp_d = bus.bus_din;
        if (phase_q != PH_LAST) begin
          phase_d = phase_q + 1'b1;
        end else begin
          phase_d = '0;
          state_d = next_step(state_q, need_q);
          case (state_q)
`ifdef MBC5_MASTER_BANK_CACHE_EN
            BANK_LO: begin
              rom_bank_d[7:0] = addr_q[21:14];
              rom_val_d       = 1'b0;
            end
            BANK_HI: begin
              rom_bank_d[8] = addr_q[22];
              rom_val_d     = 1'b1;
            end
            RAM_BANK: begin
              ram_bank_d = addr_q[16:13];
              ram_val_d  = 1'b1;
            end
`endif
            RAM_EN: ram_on_d = 1'b1;
            ACCESS: begin
              state_d = RESP;
              if (!we_q) begin
                rdata_d = rd_smp_q;
              end else if (!ram_q) begin
                // Raw MBC register write: mapper state is now unknown.
                ram_on_d = 1'b0;
`ifdef MBC5_MASTER_BANK_CACHE_EN
                rom_val_d = 1'b0;
                ram_val_d = 1'b0;
`endif
              end
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge vb_clk or posedge vb_rst) begin
    if (vb_rst) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      need_q   <= '0;
      ram_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ram_on_q <= 1'b0;
      rd_smp_q <= '0;
      rdata_q  <= '0;
`ifdef MBC5_MASTER_BANK_CACHE_EN
      rom_bank_q <= '0;
      rom_val_q  <= 1'b0;
      ram_bank_q <= '0;
      ram_val_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      need_q   <= need_d;
      ram_q    <= ram_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ram_on_q <= ram_on_d;
      rd_smp_q <= rd_smp_d;
      rdata_q  <= rdata_d;
`ifdef MBC5_MASTER_BANK_CACHE_EN
      rom_bank_q <= rom_bank_d;
      rom_val_q  <= rom_val_d;
      ram_bank_q <= ram_bank_d;
      ram_val_q  <= ram_val_d;
`endif
    end
  end

  logic [15:0] a_c;
  logic [7:0]  d_c;
  logic        wcyc, in_bus, strobe;

  // Bus outputs decode straight from state so an async reset drops them at once.
  always_comb begin
    a_c  = 16'h0000;
    d_c  = 8'h00;
    wcyc = 1'b0;
    case (state_q)
      BANK_LO:  begin a_c = 16'h2000; d_c = addr_q[21:14];         wcyc = 1'b1; end
      BANK_HI:  begin a_c = 16'h3000; d_c = {7'b0, addr_q[22]};    wcyc = 1'b1; end
      RAM_EN:   begin a_c = 16'h0000; d_c = 8'h0A;                 wcyc = 1'b1; end
      RAM_BANK: begin a_c = 16'h4000; d_c = {4'b0, addr_q[16:13]}; wcyc = 1'b1; end
      ACCESS: begin
        wcyc = we_q;
        d_c  = we_q ? wdata_q : 8'h00;
        if (ram_q)                     a_c = {3'b101, addr_q[12:0]};
        else if (we_q)                 a_c = {1'b0, addr_q[14:0]};
        else if (addr_q[22:14] == '0)  a_c = {2'b00, addr_q[13:0]};
        else                           a_c = {2'b01, addr_q[13:0]};
      end
      default: ;
    endcase
  end

  assign in_bus = (state_q != IDLE) && (state_q != RESP);
  assign strobe = (phase_q != '0) && (phase_q != PH_LAST);

  assign bus.req_ready  = (state_q == IDLE) && !vb_rst;
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.bus_a      = a_c;
  assign bus.bus_dout   = d_c;
  assign bus.bus_doe    = in_bus && wcyc;
  assign bus.bus_wr     = in_bus && wcyc && strobe;
  assign bus.bus_rd     = in_bus && !wcyc && strobe;
endmodule
